// File: rtl/fixed_multiplier.sv
// Sequential signed Q16.16 multiplier: sign-magnitude shift-add, one partial product per clock.
// CPU handshake (write_a/start/busy/done/valid/ovf) matches the companion divider.
module fixed_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write_a,
  input  logic [31:0] a_in,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        ovf,
  output logic [31:0] val,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic [31:0] val_q, val_d;

  logic [31:0] a_eff;
  logic [31:0] m;
  logic        over;

  always_comb begin
    // A write on the accept edge bypasses the register so the new operand is used.
    a_eff   = write_a ? a_in : a_q;
    m       = acc_q[47:16];
    // The one magnitude above 0x7FFFFFFF that still fits is -2^31.
    over    = (|acc_q[63:48]) || (m[31] && !(sign_q && (m == 32'h8000_0000)));

    state_d = state_q;
    a_d     = a_eff;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    val_d   = val_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          sign_d  = a_eff[31] ^ b[31];
          mag_a_d = a_eff[31] ? (~a_eff + 32'd1) : a_eff;
          mag_b_d = b[31] ? (~b + 32'd1) : b;
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        if (mag_b_q[cnt_q]) acc_d = acc_q + ({32'd0, mag_a_q} << cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (over) begin
          val_d   = 32'd0;
          ovf_d   = 1'b1;
          valid_d = 1'b0;
        end else begin
          val_d   = sign_q ? (~m + 32'd1) : m;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      mag_a_q <= 32'd0;
      mag_b_q <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      val_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      val_q   <= val_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign ovf       = ovf_q;
  assign val       = val_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fixed_multiplier.md
# fixed_multiplier

Sequential signed Q16.16 fixed-point multiplier, the companion of the Divider in the IO block. It shares the Divider's CPU-facing handshake (`write_a` / `start` / `busy` / `done` / `valid` / `ovf`), so firmware drives both units the same way. A shift-add datapath produces one partial product per clock. The block sits on the same memory-mapped IO port as the Divider.

## Interface
- No parameters; operand and result format is fixed at signed Q16.16, 32 bits.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset (low = reset).
- `start` in 1: begin a multiply; sampled only in IDLE.
- `write_a` in 1: latch `a_in` into the persistent operand A register.
- `a_in` in 32: multiplicand, Q16.16 signed.
- `b` in 32: multiplier, Q16.16 signed; sampled on the accepting `start` edge.
- `busy` out 1: calculation in progress.
- `done` out 1: one-cycle pulse when the result register updates.
- `valid` out 1: `val` holds a correct result.
- `ovf` out 1: last result overflowed the Q16.16 range.
- `val` out 32: result, Q16.16 signed.

## Operation
- States: IDLE, CALC, FINISH.
  - IDLE→CALC when `start`=1.
  - CALC→FINISH after 32 iterations (5-bit counter reaches 31).
  - FINISH→IDLE unconditionally.
- `write_a`: A register ← `a_in` on any edge, in any state.
  - A write while busy does not affect the running operation; the operand is copied at start.
- `write_a` and `start` on the same edge: the operation uses the new `a_in` (bypass); the A register is also updated.
- Accept edge (IDLE, `start`=1):
  - Record sign = a[31] XOR b[31].
  - Load |A| and |b| as 32-bit unsigned. −2^31 gives magnitude 0x80000000 with no wrap.
  - Clear the 64-bit accumulator; clear `valid` and `ovf`.
- CALC iteration i (i = 0..31): if bit i of |b| is set, accumulator += |A| << i. Equivalently, an accumulator shifts right and the multiplicand stays fixed; the result is identical.
- FINISH, with P = 64-bit magnitude product and m = P[47:16] (truncation of magnitude, i.e. rounds toward zero):
  - Overflow = P[63:48] ≠ 0, OR m > 0x7FFFFFFF unless (sign=1 AND m = 0x80000000).
  - Overflow: `val` ← 0, `ovf` ← 1, `valid` ← 0.
  - Otherwise: `val` ← sign ? −m : m (two's complement), `ovf` ← 0, `valid` ← 1.
  - A zero magnitude always yields `val` = 0 regardless of sign (no negative zero issue in two's complement).
- `start` is ignored in CALC and FINISH.
- A `start` held high re-triggers on the first IDLE edge after FINISH, giving back-to-back operations.
- `val`, `valid` and `ovf` hold their value until the next accept edge or reset.

## Timing
- Reset (`rst` low, asynchronous, any state including mid-CALC):
  - State = IDLE.
  - `busy`=0, `done`=0, `valid`=0, `ovf`=0, `val`=0.
  - A register = 0, accumulator = 0, counter = 0.
- Release of reset takes effect at the next rising edge; the first `start` can be accepted on that edge.
- With accept edge E0:
  - `busy`=1 from E0 until E33.
  - Iterations run on edges E1..E32.
  - FINISH updates `val`/`valid`/`ovf` and pulses `done`=1 at E33; `busy`=0 at E33.
  - `done` returns to 0 at E34.
- Latency: 33 clocks from accept edge to `done`.
- Throughput with `start` held: next accept at E34, next `done` at E67.
- `done` and `busy` are never high simultaneously.

## Test plan
- Basic product: reset, `write_a` with `a_in`=0x00030000, then `start` with `b`=0x00050000. Required: `busy` high for 33 cycles; `done` pulses at E33; `val`=0x000F0000, `valid`=1, `ovf`=0.
- Signed product: A=0xFFFD8000 (−2.5), `b`=0x00018000 (1.5). Required: `val`=0xFFFC4000 (−3.75), `valid`=1. Then repeat with A=0xFFFD8000, `b`=0xFFFE8000 (−1.5). Required: `val`=0x0003C000.
- Range boundary:
  - A=0x01000000 (256), `b`=0x00800000 (128). Required: `ovf`=1, `valid`=0, `val`=0.
  - A=0xFF000000 (−256), same `b`. Required: `val`=0x80000000, `valid`=1, `ovf`=0.
  - A=0x00010000, `b`=0x80000000. Required: `val`=0x80000000, `valid`=1.
- Truncation: A=0x00000001, `b`=0x00008000. Required: `val`=0. Then A=0xFFFFFFFF, `b`=0x00018000. Required: `val`=0xFFFFFFFF (magnitude 1.5 LSB truncates to 1).
- Reset mid-operation: assert `rst` low at E10 of an operation. Required: immediately `busy`=0, `done`=0, `valid`=0, `ovf`=0, `val`=0, A=0. A subsequent 3×5 operation still returns 0x000F0000.
- Held `start` plus `write_a` while busy: hold `start`=1 and write A=0x00020000 at E5 of a 3×5 operation. Required: first `done` (E33) gives 0x000F0000; second `done` (E67) gives 0x000A0000; `done` high exactly one cycle each time.
